// File: rtl/systolic_pe_array_os_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pe_array_os_if
//  Purpose  : Operand-stream / result-row bundle for the output-stationary
//             systolic array.
//  Signals  : a_in, b_in, in_valid, in_last  (producer -> array)
//             in_ready                       (array -> producer)
//             out_row, out_row_idx, out_valid, out_last, out_sat, busy
//                                            (array -> consumer)
//             out_ready                      (consumer -> array)
//  Modports : master = operand producer / result consumer side
//             slave  = the array itself
//  Revision : 1.0  initial release
// ============================================================================
interface systolic_pe_array_os_if #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16
) ();
   localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;

   logic [N*DATA_W-1:0] a_in;
   logic [N*DATA_W-1:0] b_in;
   logic                in_valid;
   logic                in_last;
   logic                in_ready;
   logic [N*OUT_W-1:0]  out_row;
   logic [c_idx_w-1:0]  out_row_idx;
   logic                out_valid;
   logic                out_last;
   logic                out_sat;
   logic                out_ready;
   logic                busy;

   modport master (
      output a_in, b_in, in_valid, in_last, out_ready,
      input  in_ready, out_row, out_row_idx, out_valid, out_last, out_sat, busy
   );

   modport slave (
      input  a_in, b_in, in_valid, in_last, out_ready,
      output in_ready, out_row, out_row_idx, out_valid, out_last, out_sat, busy
   );
endinterface
`default_nettype wire

// File: rtl/systolic_pe_array_os.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pe_array_os
//  Purpose  : N x N output-stationary systolic array computing one C = A x B
//             tile. K operand beats stream in (A columns on the west edge,
//             B rows on the north edge), the skew pipeline is flushed, then
//             C drains one saturated row per cycle under valid/ready.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - systolic_pe_array_os_if.slave
//                    a_in/b_in/in_valid/in_last/in_ready : operand beats
//                    out_row/out_row_idx/out_valid/out_last/out_sat/
//                    out_ready : result rows,  busy : array not idle
//  Revision : 1.0  initial release
// ============================================================================
module systolic_pe_array_os #(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   systolic_pe_array_os_if.slave   bus
);
   localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;
   localparam int c_cnt_w = $clog2(2 * N);
   localparam int c_pw    = 2 * DATA_W;

   localparam logic [c_cnt_w-1:0] c_flush_init = c_cnt_w'(2 * N - 2);
   localparam logic [c_idx_w-1:0] c_last_row   = c_idx_w'(N - 1);
   localparam logic [ACC_W-1:0]   c_acc_max    = '1;
   localparam logic [ACC_W-1:0]   c_out_max    = ACC_W'({OUT_W{1'b1}});

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_compute = 2'd1;
   localparam logic [1:0] c_st_flush   = 2'd2;
   localparam logic [1:0] c_st_drain   = 2'd3;

   logic [1:0]          r_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_idx_w-1:0]  r_row;

   logic w_in_ready;
   logic w_accept;
   logic w_hs;
   logic w_drain_done;

   // Skewed edge feeds into column 0 / row 0 of the PE grid.
   logic [DATA_W-1:0] w_a_west  [N];
   logic              w_av_west [N];
   logic [DATA_W-1:0] w_b_north [N];
   logic              w_bv_north[N];

   // Registered hop outputs of every PE, and the accumulators.
   logic [DATA_W-1:0] w_a_east  [N][N];
   logic              w_av_east [N][N];
   logic [DATA_W-1:0] w_b_south [N][N];
   logic              w_bv_south[N][N];
   logic [ACC_W-1:0]  w_acc     [N][N];

   assign w_in_ready   = (r_state == c_st_idle) || (r_state == c_st_compute);
   assign w_accept     = bus.in_valid && w_in_ready;
   assign w_hs         = (r_state == c_st_drain) && bus.out_ready;
   assign w_drain_done = w_hs && (r_row == c_last_row);

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_row   <= '0;
      end else begin
         case (r_state)
            c_st_idle, c_st_compute: begin
               if (w_accept) begin
                  if (bus.in_last) begin
                     r_cnt <= c_flush_init;
                     // A 1x1 array has no skew to flush.
                     r_state <= (c_flush_init == '0) ? c_st_drain : c_st_flush;
                  end else begin
                     r_state <= c_st_compute;
                  end
               end
            end
            c_st_flush: begin
               // Counter is decremented to zero on the edge that enters DRAIN,
               // giving exactly 2N-2 flush cycles.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt <= c_cnt_w'(1)) begin
                  r_state <= c_st_drain;
               end
            end
            c_st_drain: begin
               if (w_hs) begin
                  if (r_row == c_last_row) begin
                     r_row   <= '0;
                     r_state <= c_st_idle;
                  end else begin
                     r_row <= r_row + 1'b1;
                  end
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Input skew: lane i of A and lane i of B are each delayed i cycles,
   // carrying their own valid so idle cycles travel as bubbles.
   // ------------------------------------------------------------------------
   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_skew
         if (gi == 0) begin : g_direct
            assign w_a_west[gi]   = bus.a_in[gi*DATA_W +: DATA_W];
            assign w_av_west[gi]  = w_accept;
            assign w_b_north[gi]  = bus.b_in[gi*DATA_W +: DATA_W];
            assign w_bv_north[gi] = w_accept;
         end else begin : g_delay
            logic [DATA_W-1:0] r_ad [gi];
            logic [DATA_W-1:0] r_bd [gi];
            logic [gi-1:0]     r_av;
            logic [gi-1:0]     r_bv;

            always_ff @(posedge clk) begin
               if (rst) begin
                  for (int k = 0; k < gi; k++) begin
                     r_ad[k] <= '0;
                     r_bd[k] <= '0;
                  end
                  r_av <= '0;
                  r_bv <= '0;
               end else begin
                  r_ad[0] <= bus.a_in[gi*DATA_W +: DATA_W];
                  r_bd[0] <= bus.b_in[gi*DATA_W +: DATA_W];
                  r_av[0] <= w_accept;
                  r_bv[0] <= w_accept;
                  for (int k = 1; k < gi; k++) begin
                     r_ad[k] <= r_ad[k-1];
                     r_bd[k] <= r_bd[k-1];
                     r_av[k] <= r_av[k-1];
                     r_bv[k] <= r_bv[k-1];
                  end
               end
            end

            assign w_a_west[gi]   = r_ad[gi-1];
            assign w_av_west[gi]  = r_av[gi-1];
            assign w_b_north[gi]  = r_bd[gi-1];
            assign w_bv_north[gi] = r_bv[gi-1];
         end
      end

      // ---------------------------------------------------------------------
      // PE grid
      // ---------------------------------------------------------------------
      for (gi = 0; gi < N; gi++) begin : g_pe_row
         for (gj = 0; gj < N; gj++) begin : g_pe_col
            logic [DATA_W-1:0] w_a;
            logic              w_av;
            logic [DATA_W-1:0] w_b;
            logic              w_bv;
            logic [c_pw-1:0]   w_prod;
            logic [ACC_W:0]    w_sum;
            logic [DATA_W-1:0] r_a;
            logic              r_av;
            logic [DATA_W-1:0] r_b;
            logic              r_bv;
            logic [ACC_W-1:0]  r_acc;

            if (gj == 0) begin : g_west_edge
               assign w_a  = w_a_west[gi];
               assign w_av = w_av_west[gi];
            end else begin : g_west_pe
               assign w_a  = w_a_east[gi][gj-1];
               assign w_av = w_av_east[gi][gj-1];
            end

            if (gi == 0) begin : g_north_edge
               assign w_b  = w_b_north[gj];
               assign w_bv = w_bv_north[gj];
            end else begin : g_north_pe
               assign w_b  = w_b_south[gi-1][gj];
               assign w_bv = w_bv_south[gi-1][gj];
            end

            assign w_prod = c_pw'(w_a) * c_pw'(w_b);
            // One guard bit catches the overflow that triggers saturation.
            assign w_sum  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod);

            always_ff @(posedge clk) begin
               if (rst) begin
                  r_a   <= '0;
                  r_av  <= 1'b0;
                  r_b   <= '0;
                  r_bv  <= 1'b0;
                  r_acc <= '0;
               end else begin
                  r_a  <= w_a;
                  r_av <= w_av;
                  r_b  <= w_b;
                  r_bv <= w_bv;
                  if (w_drain_done) begin
                     r_acc <= '0;
                  end else if (w_av && w_bv) begin
                     r_acc <= w_sum[ACC_W] ? c_acc_max : w_sum[ACC_W-1:0];
                  end
               end
            end

            assign w_a_east[gi][gj]   = r_a;
            assign w_av_east[gi][gj]  = r_av;
            assign w_b_south[gi][gj]  = r_b;
            assign w_bv_south[gi][gj] = r_bv;
            assign w_acc[gi][gj]      = r_acc;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Drain path: select row r_row, clip each lane to OUT_W bits.
   // ------------------------------------------------------------------------
   logic [ACC_W-1:0]   w_sel [N];
   logic [N*OUT_W-1:0] w_out_row;
   logic               w_sat;
   logic               w_drain;

   assign w_drain = (r_state == c_st_drain);

   always_comb begin
      w_out_row = '0;
      w_sat     = 1'b0;
      for (int j = 0; j < N; j++) begin
         w_sel[j] = '0;
         for (int r = 0; r < N; r++) begin
            if (r_row == c_idx_w'(r)) begin
               w_sel[j] = w_acc[r][j];
            end
         end
         if (w_sel[j] > c_out_max) begin
            w_out_row[j*OUT_W +: OUT_W] = '1;
            w_sat = 1'b1;
         end else begin
            w_out_row[j*OUT_W +: OUT_W] = w_sel[j][OUT_W-1:0];
         end
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.busy        = (r_state != c_st_idle);
   assign bus.out_valid   = w_drain;
   assign bus.out_row     = w_drain ? w_out_row : '0;
   assign bus.out_row_idx = r_row;
   assign bus.out_last    = w_drain && (r_row == c_last_row);
   assign bus.out_sat     = w_drain && w_sat;

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe_array_os.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_pe_array_os
//  Purpose  : Self-checking bench for systolic_pe_array_os (N=2, DATA_W=8,
//             ACC_W=20, OUT_W=16). Expected rows come from a plain matrix
//             product with saturation applied by arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_pe_array_os;
   localparam int N      = 2;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 20;
   localparam int OUT_W  = 16;
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int KMAX   = 24;
   localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
   localparam longint OUT_MAX = (64'd1 << OUT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   int unsigned ma [N][KMAX];
   int unsigned mb [KMAX][N];
   longint      exp_c [N][N];

   always #5 clk = ~clk;

   systolic_pe_array_os_if #(.N(N), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

   systolic_pe_array_os #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- reference model ----------------
   function automatic void model(input int k);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            longint s = 0;
            for (int kk = 0; kk < k; kk++) s += longint'(ma[i][kk]) * longint'(mb[kk][j]);
            exp_c[i][j] = (s > ACC_MAX) ? ACC_MAX : s;
         end
   endfunction

   function automatic logic [N*OUT_W-1:0] exp_row(input int r);
      logic [N*OUT_W-1:0] v = '0;
      for (int j = 0; j < N; j++)
         v[j*OUT_W +: OUT_W] = OUT_W'((exp_c[r][j] > OUT_MAX) ? OUT_MAX : exp_c[r][j]);
      return v;
   endfunction

   function automatic logic exp_sat(input int r);
      logic s = 1'b0;
      for (int j = 0; j < N; j++) if (exp_c[r][j] > OUT_MAX) s = 1'b1;
      return s;
   endfunction

   task automatic load_matmul();
      ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
      mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
   endtask

   // ---------------- stimulus ----------------
   task automatic send_beats(input int k, input int bub_lo, input int bub_hi, input bit with_last);
      for (int kk = 0; kk < k; kk++) begin
         if (kk > 0) begin
            repeat ($urandom_range(bub_hi, bub_lo)) begin
               bus.in_valid = 1'b0;
               bus.in_last  = 1'b0;
               @(posedge clk); #1;
            end
         end
         for (int i = 0; i < N; i++) begin
            bus.a_in[i*DATA_W +: DATA_W] = DATA_W'(ma[i][kk]);
            bus.b_in[i*DATA_W +: DATA_W] = DATA_W'(mb[kk][i]);
         end
         bus.in_valid = 1'b1;
         bus.in_last  = with_last && (kk == k - 1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.out_sat} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: got in_ready/busy/valid/last/sat=%b required 10000",
                  {bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.out_sat});
      end
      checks++;
      if (bus.out_row !== '0 || bus.out_row_idx !== '0) begin
         errors++;
         $display("FAIL reset_row: got row=%h idx=%0d required 0/0", bus.out_row, bus.out_row_idx);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_matmul();
      int cyc;
      load_matmul();
      model(2);
      bus.out_ready = 1'b1;
      send_beats(2, 0, 0, 1'b1);
      checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL matmul_flush_state: got busy=%b in_ready=%b required 1/0", bus.busy, bus.in_ready);
      end
      wait_valid(cyc);
      checks++;
      if (cyc !== 2 * N - 2) begin
         errors++;
         $display("FAIL matmul_latency: got %0d flush cycles required %0d", cyc, 2 * N - 2);
      end
      for (int r = 0; r < N; r++) begin
         checks++;
         if (bus.out_row !== exp_row(r)) begin
            errors++;
            $display("FAIL matmul_row%0d: got %h required %h", r, bus.out_row, exp_row(r));
         end
         checks++;
         if ({bus.out_valid, bus.out_last, bus.out_sat} !== {1'b1, r == N - 1, exp_sat(r)} ||
             bus.out_row_idx !== IDX_W'(r)) begin
            errors++;
            $display("FAIL matmul_flags%0d: got valid/last/sat=%b idx=%0d required %b idx=%0d", r,
                     {bus.out_valid, bus.out_last, bus.out_sat}, bus.out_row_idx,
                     {1'b1, r == N - 1, exp_sat(r)}, r);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL matmul_done: got busy=%b in_ready=%b valid=%b required 0/1/0",
                  bus.busy, bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_bubbles();
      int cyc;
      load_matmul();
      model(2);
      bus.out_ready = 1'b1;
      send_beats(2, 2, 2, 1'b1);
      wait_valid(cyc);
      checks++;
      if (cyc !== 2 * N - 2) begin
         errors++;
         $display("FAIL bubbles_latency: got %0d required %0d", cyc, 2 * N - 2);
      end
      for (int r = 0; r < N; r++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_row !== exp_row(r) || bus.out_row_idx !== IDX_W'(r)) begin
            errors++;
            $display("FAIL bubbles_row%0d: got valid=%b row=%h idx=%0d required 1 %h %0d", r,
                     bus.out_valid, bus.out_row, bus.out_row_idx, exp_row(r), r);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      load_matmul();
      model(2);
      bus.out_ready = 1'b0;
      send_beats(2, 0, 0, 1'b1);
      wait_valid(cyc);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_row !== exp_row(0) || bus.out_row_idx !== '0) begin
            errors++;
            $display("FAIL backpressure_hold%0d: got valid=%b row=%h idx=%0d required 1 %h 0", s,
                     bus.out_valid, bus.out_row, bus.out_row_idx, exp_row(0));
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      for (int r = 0; r < N; r++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_row !== exp_row(r) || bus.out_row_idx !== IDX_W'(r)) begin
            errors++;
            $display("FAIL backpressure_row%0d: got valid=%b row=%h idx=%0d required 1 %h %0d", r,
                     bus.out_valid, bus.out_row, bus.out_row_idx, exp_row(r), r);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_done: got busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      for (int i = 0; i < N; i++)
         for (int kk = 0; kk < 2; kk++) begin
            ma[i][kk] = 255;
            mb[kk][i] = 255;
         end
      model(2);
      bus.out_ready = 1'b1;
      send_beats(2, 0, 0, 1'b1);
      wait_valid(cyc);
      for (int r = 0; r < N; r++) begin
         checks++;
         if (bus.out_row !== exp_row(r) || bus.out_sat !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL saturation_row%0d: got row=%h sat=%b valid=%b required %h 1 1", r,
                     bus.out_row, bus.out_sat, bus.out_valid, exp_row(r));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_tile();
      int cyc;
      load_matmul();
      bus.out_ready = 1'b1;
      send_beats(1, 0, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_state: got busy=%b in_ready=%b required 0/1", bus.busy, bus.in_ready);
      end
      model(2);
      send_beats(2, 0, 0, 1'b1);
      wait_valid(cyc);
      for (int r = 0; r < N; r++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_row !== exp_row(r) || bus.out_row_idx !== IDX_W'(r)) begin
            errors++;
            $display("FAIL reset_mid_row%0d: got valid=%b row=%h idx=%0d required 1 %h %0d", r,
                     bus.out_valid, bus.out_row, bus.out_row_idx, exp_row(r), r);
         end
         @(posedge clk); #1;
      end
   endtask

   // Consecutive random tiles with no idle gap between the final drain
   // handshake and the next tile's first beat.
   task automatic test_random_back_to_back();
      int cyc;
      int k;
      for (int t = 0; t < 8; t++) begin
         k = $urandom_range(8, 1);
         for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < N; i++) begin
               ma[i][kk] = (t == 7) ? 255 : $urandom_range(255, 0);
               mb[kk][i] = (t == 7) ? 255 : $urandom_range(255, 0);
            end
         model(k);
         bus.out_ready = 1'b1;
         send_beats(k, 0, 2, 1'b1);
         wait_valid(cyc);
         checks++;
         if (cyc !== 2 * N - 2) begin
            errors++;
            $display("FAIL random%0d_latency: got %0d required %0d", t, cyc, 2 * N - 2);
         end
         for (int r = 0; r < N; r++) begin
            repeat ($urandom_range(2, 0)) begin
               bus.out_ready = 1'b0;
               @(posedge clk); #1;
            end
            bus.out_ready = 1'b1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_row !== exp_row(r) || bus.out_row_idx !== IDX_W'(r) ||
                bus.out_sat !== exp_sat(r) || bus.out_last !== (r == N - 1)) begin
               errors++;
               $display("FAIL random%0d_row%0d: got valid=%b row=%h idx=%0d sat=%b last=%b required 1 %h %0d %b %b",
                        t, r, bus.out_valid, bus.out_row, bus.out_row_idx, bus.out_sat, bus.out_last,
                        exp_row(r), r, exp_sat(r), r == N - 1);
            end
            @(posedge clk); #1;
         end
         checks++;
         if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL random%0d_free: got in_ready=%b busy=%b required 1/0", t, bus.in_ready, bus.busy);
         end
      end
   endtask

   initial begin
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_matmul();
      test_bubbles();
      test_backpressure();
      test_saturation();
      test_reset_mid_tile();
      test_random_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire

// File: doc/systolic_pe_array_os.md
Name: systolic_pe_array_os

Overview:
- Parametrised N x N output-stationary systolic array built from multiply-accumulate processing elements.
- Computes one C = A x B tile, with A N x K, B K x N and K unbounded. Streams K beats in, flushes the skew pipeline, then drains C one row per cycle under valid/ready backpressure.
- Adds internal input skewing, bubble tolerance, saturation and a drain FSM, none of which the single-PE computation block has.
- Sits between the operand buffers and the result writeback.

Parameters:
- N, 4: array rows and columns (N >= 1).
- DATA_W, 8: unsigned operand width.
- ACC_W, 24: unsigned accumulator width (ACC_W >= 2*DATA_W).
- OUT_W, 16: unsigned result width after saturation (OUT_W <= ACC_W).

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- a_in, in, N*DATA_W: west edge; lane i = A[i][k] at bits [i*DATA_W +: DATA_W].
- b_in, in, N*DATA_W: north edge; lane j = B[k][j].
- in_valid, in, 1: beat k present on a_in/b_in.
- in_last, in, 1: qualifies the final beat of the tile.
- in_ready, out, 1: array accepts beats.
- out_row, out, N*OUT_W: saturated row r of C; lane j = C[r][j].
- out_row_idx, out, $clog2(N) (min 1): row index r.
- out_valid, out, 1: out_row is valid.
- out_last, out, 1: high with out_valid when r = N-1.
- out_sat, out, 1: at least one lane of the current row was clipped.
- out_ready, in, 1: consumer accepts the row.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-tile):
  - State goes to IDLE; all accumulators, skew registers, PE data/valid registers and the row counter clear to 0.
  - While in IDLE: out_valid=0, out_last=0, out_sat=0, out_row=0, out_row_idx=0, busy=0, in_ready=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
  - Skew: row-lane i is delayed i cycles and column-lane j is delayed j cycles, each with its own valid bit.
  - A cycle with no accepted beat injects valid=0, so bubbles are legal and do not alter results.
- PE(i,j):
  - Registers its a/valid eastward and b/valid southward, one cycle per hop.
  - Accumulator adds a*b only when its local valid is high.
  - Beat k accepted at edge t updates PE(i,j) at edge t+i+j.
  - Accumulator saturates at 2^ACC_W-1 and never wraps.
- FSM:
  - IDLE: in_ready=1. An accepted beat moves to COMPUTE; an accepted beat with in_last moves directly to FLUSH.
  - COMPUTE: in_ready=1. An accepted beat with in_last moves to FLUSH and loads the flush counter with 2N-2. in_last without in_valid is ignored.
  - FLUSH: in_ready=0. Counter decrements each cycle; at 0 the FSM moves to DRAIN. If N=1 (count 0), FLUSH is skipped and the FSM goes straight to DRAIN.
  - DRAIN: in_ready=0, out_valid=1, out_row_idx=r (starting at 0).
    - out_row lane j = min(acc[r][j], 2^OUT_W-1); out_sat = OR of the clip flags for row r.
    - A handshake (out_valid && out_ready) advances r.
    - A handshake at r=N-1 returns to IDLE and clears all accumulators and r on the same edge.
    - With out_ready=0, all outputs hold stable.
- Latency: if the in_last beat is accepted at the edge ending cycle c, out_valid first rises in cycle c+2N-1. The final drain handshake frees the array for a new tile on the next cycle.
- Outputs are combinational from state, r and the accumulators; there are no combinational paths from the inputs to the outputs.

Test Plan (N=2, DATA_W=8, ACC_W=20, OUT_W=16):
- Reset: rst=1 for 2 cycles.
  - Required: in_ready=1, busy=0, out_valid=0, out_row=0.
- Matmul: A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Beat0 a_in=(1,3), b_in=(5,6); beat1 a_in=(2,4), b_in=(7,8), in_last=1; out_ready=1.
  - Required: 2 FLUSH cycles, then out_row=(19,22) with idx 0, then (43,50) with idx 1 and out_last=1.
  - Required: out_sat=0; busy=0 afterwards.
- Bubbles: same tile with in_valid=0 for 2 cycles between beat0 and beat1.
  - Required: identical rows (19,22) and (43,50).
- Backpressure: out_ready=0 for the first 3 DRAIN cycles.
  - Required: out_row holds (19,22), idx 0, out_valid=1 for all 3 cycles; row 1 appears only after out_ready=1.
- Saturation: 2 beats with all lanes 255 (each C element = 130050).
  - Required: every lane = 65535, out_sat=1 on both rows.
- Reset mid-tile: rst pulsed after beat0 of the matmul tile, then the full matmul tile is replayed.
  - Required: rows (19,22) and (43,50), with no residue from the aborted beat.
